// File: rtl/ifetch_pkg.sv
// Shared widths, reset defaults and entry/word types for the fetch unit and the instruction ROM.
package ifetch_pkg;
  localparam int IF_ADDR_W = 8;
  localparam int IF_DATA_W = 32;
  localparam logic [IF_ADDR_W-1:0] IF_RESET_PC  = 8'h00;
  localparam logic [IF_DATA_W-1:0] IF_HALT_WORD = 32'h0000_000D;

  typedef logic [IF_ADDR_W-1:0] addr_t;
  typedef logic [IF_DATA_W-1:0] data_t;

  typedef struct packed {
    data_t instr;
    addr_t pc;
  } ifb_entry_t;
endpackage

// File: rtl/ifetch_buf.sv
// Two-entry synchronous FIFO holding fetched {instr, pc} pairs; flush empties it in one edge.
module ifetch_buf import ifetch_pkg::*; #(
  parameter int W = $bits(ifb_entry_t)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [1:0]   count,
  output logic [W-1:0] head
);
  logic [1:0][W-1:0] mem;
  logic              wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign do_pop  = pop & (count != 2'd0);
  assign do_push = push & ((count != 2'd2) | do_pop);
  // Gate the head so an empty buffer never shows a stale entry.
  assign head    = (count != 2'd0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, ROM address issue, redirect handling and a 2-deep decode buffer.
// Optional halt-on-HALT_WORD behaviour is enabled with `define IFETCH_HALT_EN.
module instr_fetch import ifetch_pkg::*; #(
  parameter int ADDR_W = IF_ADDR_W,
  parameter int DATA_W = IF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = IF_RESET_PC
`ifdef IFETCH_HALT_EN
  , parameter logic [DATA_W-1:0] HALT_WORD = IF_HALT_WORD
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);
  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc, req_pc;
  logic              inflight;
  logic [1:0]        count;
  logic [2:0]        occ;
  logic              pop, push, issue, halt_hit;
  entry_t            din, head;

  assign imem_addr = redirect_valid ? redirect_pc : fetch_pc;
  assign pop       = if_valid & if_ready;
  assign occ       = {1'b0, count} - {2'b0, pop} + {2'b0, inflight};
  // A redirect empties the buffer and kills the in-flight read, so it always has room.
  assign issue     = redirect_valid | (~halted & (occ < 3'd2));
  assign push      = inflight & ~redirect_valid;
  assign din       = {imem_data, req_pc};

  ifetch_buf #(.W($bits(entry_t))) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (din),
    .count (count),
    .head  (head)
  );

  assign if_valid = (count != 2'd0);
  assign if_instr = head.instr;
  assign if_pc    = head.pc;

`ifdef IFETCH_HALT_EN
  assign halt_hit = push & (imem_data == HALT_WORD);

  always_ff @(posedge clk) begin
    if (!rst_n || redirect_valid) halted <= 1'b0;
    else if (halt_hit)            halted <= 1'b1;
  end
`else
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      // A read issued on the same edge the halt word lands is dropped.
      inflight <= issue & ~halt_hit;
      if (issue) begin
        req_pc   <= imem_addr;
        fetch_pc <= imem_addr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus queues expected beats, a negedge monitor checks them.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [7:0]  if_pc;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        halted;
  bit          halt_rom = 1'b0;

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] instr;
  } beat_t;

  beat_t exp_q[$];
  int    n_chk = 0;
  int    n_pass = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  function automatic logic [31:0] rom_word(input logic [7:0] a);
    if (halt_rom && a == 8'h03) return 32'h0000_000D;
    return 32'h1000_0000 + {24'h0, a};
  endfunction

  // Synchronous ROM: address sampled at the edge, data valid the following cycle.
  always @(posedge clk) imem_data <= rom_word(imem_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic expect_run(input logic [7:0] start, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.pc    = start + 8'(i);
      b.instr = rom_word(b.pc);
      exp_q.push_back(b);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) tick();
    if_ready = 1'b0;
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (rst_n && if_valid && if_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_beat: pc %0h instr %0h with nothing expected", if_pc, if_instr);
      end else begin
        e = exp_q.pop_front();
        chk("beat_pc", 64'(if_pc), 64'(e.pc));
        chk("beat_instr", 64'(if_instr), 64'(e.instr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    if_ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 64'(if_valid), 64'd0);
    chk("rst_instr", 64'(if_instr), 64'd0);
    chk("rst_pc", 64'(if_pc), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'h00);

    // Streaming from reset, then backpressure at head pc 4.
    expect_run(8'h00, 12);
    rst_n = 1'b1;
    tick();
    chk("lat_edge1_valid", 64'(if_valid), 64'd0);
    tick();
    chk("lat_edge2_valid", 64'(if_valid), 64'd1);
    chk("lat_edge2_pc", 64'(if_pc), 64'h00);
    for (int k = 1; k < 5; k++) begin
      tick();
      chk("stream_valid", 64'(if_valid), 64'd1);
      chk("stream_pc", 64'(if_pc), 64'(k));
    end
    if_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_head_pc", 64'(if_pc), 64'h04);
      chk("bp_head_instr", 64'(if_instr), 64'h1000_0004);
      chk("bp_addr", 64'(imem_addr), 64'h06);
      tick();
    end
    if_ready = 1'b1;
    drain("bp");

    // Redirect with a full buffer.
    tick();
    tick();
    chk("full_valid", 64'(if_valid), 64'd1);
    expect_run(8'h40, 4);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h40;
    tick();
    redirect_valid = 1'b0;
    chk("redir_valid_low", 64'(if_valid), 64'd0);
    tick();
    chk("redir_tgt_valid", 64'(if_valid), 64'd1);
    chk("redir_tgt_pc", 64'(if_pc), 64'h40);
    chk("redir_tgt_instr", 64'(if_instr), 64'h1000_0040);
    if_ready = 1'b1;
    drain("redir40");

    // Redirect while a read is in flight, across the address wrap.
    expect_run(8'hFE, 4);
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFE;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_valid_low", 64'(if_valid), 64'd0);
    if_ready = 1'b1;
    drain("wrap");

    // Reset mid-stream.
    chk("pre_rst_valid", 64'(if_valid), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_valid", 64'(if_valid), 64'd0);
    chk("mid_rst_pc", 64'(if_pc), 64'd0);
    chk("mid_rst_instr", 64'(if_instr), 64'd0);
    chk("mid_rst_addr", 64'(imem_addr), 64'h00);
    expect_run(8'h00, 4);
    if_ready = 1'b1;
    drain("restart");

`ifdef IFETCH_HALT_EN
    halt_rom = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expect_run(8'h00, 4);
    if_ready = 1'b1;
    repeat (10) tick();
    chk("halt_set", 64'(halted), 64'd1);
    chk("halt_valid", 64'(if_valid), 64'd0);
    chk("halt_beats", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    expect_run(8'h10, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h10;
    tick();
    redirect_valid = 1'b0;
    chk("halt_cleared", 64'(halted), 64'd0);
    drain("halt_redir");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
